id_scoreboard: RTL

Parametrised register-hazard scoreboard for the ID stage, generalising the single-case load-use stall into per-register pending tracking. It handles fixed-latency results (ALU, load, MUL) and variable-latency results (DIV), WAW ordering, and flush of the most recently issued instruction. It sits between the decoder/control unit and the ID/EX pipeline register, and gates issue with a valid/ready handshake.

---
 rtl/sb_pkg.sv | 19 +
 rtl/sb_entry.sv | 39 +++
 rtl/id_scoreboard.sv | 98 +++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared types for the ID-stage register scoreboard.
// The per-entry latency counter is lat_t, so a top-level LAT_W override
// must be matched by SB_LAT_W here.
package sb_pkg;

    localparam int SB_NUM_REGS = 32;
    localparam int SB_LAT_W    = 3;
    localparam int REG_IDX_W   = $clog2(SB_NUM_REGS);

    typedef logic [SB_LAT_W-1:0] lat_t;

    // is_var marks a variable-latency producer that waits for wb_valid
    typedef struct packed {
        logic pend;
        logic is_var;
        lat_t cnt;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One tracked register: pending flag, variable-latency flag, countdown.
// Clear priority: flush > writeback > countdown. A set never meets a
// pending entry because the top stalls WAW issues.
module sb_entry
    import sb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic set_var,
    input  lat_t set_lat,
    input  logic wb_clr,
    input  logic flush_clr,
    output logic pend
);

    sb_entry_t q;

    // entry state update with flush/wb/countdown priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush_clr) begin
            q <= '0;
        end else if (wb_clr && q.pend && q.is_var) begin
            q <= '0;
        end else if (set) begin
            q.pend   <= 1'b1;
            q.is_var <= set_var;
            q.cnt    <= set_var ? lat_t'(0) : set_lat;
        end else if (q.pend && !q.is_var) begin
            if (q.cnt == lat_t'(1)) q <= '0;
            else                    q.cnt <= q.cnt - lat_t'(1);
        end
    end

    assign pend = q.pend;

endmodule

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard between decode and the ID/EX register.
// Tracks RAW/WAW hazards per register for fixed and variable latency
// producers, and can cancel the instruction issued on the previous edge.
// Optional stall counter: define SB_PERF_CNT_EN.
module id_scoreboard
    import sb_pkg::*;
#(
    parameter  int NUM_REGS = SB_NUM_REGS,
    parameter  int NUM_SRC  = 2,
    parameter  int LAT_W    = SB_LAT_W,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [NUM_SRC*IDX_W-1:0] src_idx,
    input  logic [NUM_SRC-1:0]       src_used,
    input  logic [IDX_W-1:0]         dst_idx,
    input  logic                     dst_we,
    input  logic [LAT_W-1:0]         dst_lat,
    input  logic                     wb_valid,
    input  logic [IDX_W-1:0]         wb_idx,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      pending,
    output logic [15:0]              stall_cnt
);

    // padded to the full index range so any index reads a defined bit
    logic [2**IDX_W-1:0] pend_ext;
    logic                raw;
    logic                waw;
    logic                fire;
    logic                last_v;
    logic [IDX_W-1:0]    last_idx;

    assign pend_ext[0] = 1'b0;

    if (NUM_REGS < 2**IDX_W) begin : g_pad
        assign pend_ext[2**IDX_W-1:NUM_REGS] = '0;
    end

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_ent
        sb_entry u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .set       (fire && dst_we && dst_idx == IDX_W'(i)),
            .set_var   (dst_lat == '0),
            .set_lat   (lat_t'(dst_lat)),
            .wb_clr    (wb_valid && wb_idx == IDX_W'(i)),
            .flush_clr (flush && last_v && last_idx == IDX_W'(i)),
            .pend      (pend_ext[i])
        );
    end

    assign pending = pend_ext[NUM_REGS-1:0];

    // RAW: any enabled source slot reads a pending register
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_used[k] && pend_ext[src_idx[k*IDX_W +: IDX_W]]) raw = 1'b1;
        end
    end

    assign waw         = dst_we && pend_ext[dst_idx];
    assign issue_ready = !flush && !raw && !waw;
    assign fire        = issue_valid && issue_ready;

    // remember the most recent tracked write so a flush can cancel it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_v   <= 1'b0;
            last_idx <= '0;
        end else begin
            last_v   <= fire && dst_we && (dst_idx != '0);
            last_idx <= dst_idx;
        end
    end

`ifdef SB_PERF_CNT_EN
    logic [15:0] stall_q;

    // saturating count of cycles an instruction waits in ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (issue_valid && !issue_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
